// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// register address width, NOP encoding and the load-use detect function.
package hazard_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_MDU_WAIT = 2'd2
    } hz_state_t;

    // x0 is hardwired to zero, so a load targeting it can never create a hazard
    function automatic logic load_use(
        input logic              mem_read,
        input logic              rd_wen,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs1,
        input logic              rs1_en,
        input logic [REG_AW-1:0] rs2,
        input logic              rs2_en
    );
        return mem_read && rd_wen && (rd != '0) &&
               ((rs1_en && (rs1 == rd)) || (rs2_en && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard controller performance counters.
module hazard_ctrl_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Holds at all-ones instead of wrapping so long runs read as "at least max"
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall, flush and bubble generation for
// load-use hazards, multi-cycle MDU ops, data-memory waits and branch redirects.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_MAX_CYC = 64,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_addr_d,
    input  logic [REG_AW-1:0] rs2_addr_d,
    input  logic              rs1_en_d,
    input  logic              rs2_en_d,
    input  logic [REG_AW-1:0] rd_addr_e,
    input  logic              rd_wen_e,
    input  logic              mem_read_e,
    input  logic              mdu_start_e,
    input  logic              mdu_done,
    input  logic              branch_taken_e,
    input  logic              dmem_req_m,
    input  logic              dmem_ready,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              bubble_m,
    output logic              bubble_w,
    output logic              mdu_timeout,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int CYC_W = $clog2(MDU_MAX_CYC) + 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MDU_MAX_CYC - 1);

    hz_state_t        state, next_state;
    logic [CYC_W-1:0] mdu_cyc;
    logic [CYC_W-1:0] mdu_cyc_inc;
    logic             timeout_q;
    logic             tail_eval;
    logic             flush_branch;
    logic             lu;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    assign mdu_cyc_inc = mdu_cyc + CYC_W'(1);

    // RUN and the MEM_WAIT release cycle share the R2..R4 priority chain via tail_eval
    always_comb begin
        next_state   = state;
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        stall_m      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        bubble_m     = 1'b0;
        bubble_w     = 1'b0;
        flush_branch = 1'b0;
        tail_eval    = 1'b0;
        mdu_timeout  = timeout_q;
        stall_cnt    = stall_cnt_q;
        flush_cnt    = flush_cnt_q;
        lu = load_use(mem_read_e, rd_wen_e, rd_addr_e,
                      rs1_addr_d, rs1_en_d, rs2_addr_d, rs2_en_d);

        case (state)
            HZ_RUN: begin
                if (dmem_req_m && !dmem_ready) begin
                    {stall_f, stall_d, stall_e, stall_m, bubble_w} = '1;
                    next_state = HZ_MEM_WAIT;
                end else begin
                    tail_eval = 1'b1;
                end
            end
            HZ_MEM_WAIT: begin
                if (!dmem_ready) begin
                    {stall_f, stall_d, stall_e, stall_m, bubble_w} = '1;
                end else begin
                    next_state = HZ_RUN;
                    tail_eval  = 1'b1;
                end
            end
            HZ_MDU_WAIT: begin
                if (!mdu_done) begin
                    {stall_f, stall_d, stall_e, bubble_m} = '1;
                end else begin
                    next_state = HZ_RUN;
                end
            end
            default: next_state = HZ_RUN;
        endcase

        if (tail_eval) begin
            if (mdu_start_e && !mdu_done) begin
                {stall_f, stall_d, stall_e, bubble_m} = '1;
                next_state = HZ_MDU_WAIT;
            end else if (branch_taken_e) begin
                flush_d      = 1'b1;
                flush_e      = 1'b1;
                flush_branch = 1'b1;
            end else if (lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end

        if (rst) begin
            next_state   = HZ_RUN;
            {stall_f, stall_d, stall_e, stall_m} = '0;
            {flush_d, flush_e, bubble_m, bubble_w} = '0;
            flush_branch = 1'b0;
            mdu_timeout  = 1'b0;
            stall_cnt    = '0;
            flush_cnt    = '0;
        end
    end

    // mdu_cyc saturates at CYC_LAST; the timeout flag is raised as it gets there
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HZ_RUN;
            mdu_cyc   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == HZ_MDU_WAIT) && !mdu_done) begin
                if (mdu_cyc != CYC_LAST) begin
                    mdu_cyc <= mdu_cyc_inc;
                    if (mdu_cyc_inc == CYC_LAST) begin
                        timeout_q <= 1'b1;
                    end
                end
            end else begin
                mdu_cyc <= '0;
            end
        end
    end

    hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_f),
        .count (stall_cnt_q)
    );

    hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_branch),
        .count (flush_cnt_q)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; each task covers one scenario
// with hand-computed control vectors and counter values.
module tb_hazard_ctrl;

    localparam int CNT_W = 8;

    // Control vector order: stall_f stall_d stall_e stall_m flush_d flush_e bubble_m bubble_w mdu_timeout
    localparam logic [8:0] C_NONE   = 9'b000000000;
    localparam logic [8:0] C_LU     = 9'b110001000;
    localparam logic [8:0] C_BR     = 9'b000011000;
    localparam logic [8:0] C_MEM    = 9'b111100010;
    localparam logic [8:0] C_MDU    = 9'b111000100;
    localparam logic [8:0] C_MDU_TO = 9'b111000101;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       rs1_addr_d, rs2_addr_d, rd_addr_e;
    logic             rs1_en_d, rs2_en_d, rd_wen_e, mem_read_e;
    logic             mdu_start_e, mdu_done, branch_taken_e, dmem_req_m, dmem_ready;
    logic             stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic             bubble_m, bubble_w, mdu_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [8:0]       ctrl;

    int total = 0;
    int bad   = 0;

    assign ctrl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_m, bubble_w, mdu_timeout};

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_MAX_CYC(8), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .rs1_addr_d     (rs1_addr_d),
        .rs2_addr_d     (rs2_addr_d),
        .rs1_en_d       (rs1_en_d),
        .rs2_en_d       (rs2_en_d),
        .rd_addr_e      (rd_addr_e),
        .rd_wen_e       (rd_wen_e),
        .mem_read_e     (mem_read_e),
        .mdu_start_e    (mdu_start_e),
        .mdu_done       (mdu_done),
        .branch_taken_e (branch_taken_e),
        .dmem_req_m     (dmem_req_m),
        .dmem_ready     (dmem_ready),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .stall_m        (stall_m),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .bubble_m       (bubble_m),
        .bubble_w       (bubble_w),
        .mdu_timeout    (mdu_timeout),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_addr_d = 5'd0; rs2_addr_d = 5'd0; rd_addr_e = 5'd0;
        rs1_en_d = 1'b0; rs2_en_d = 1'b0; rd_wen_e = 1'b0; mem_read_e = 1'b0;
        mdu_start_e = 1'b0; mdu_done = 1'b0; branch_taken_e = 1'b0;
        dmem_req_m = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // lw x5 in EX, add x6,x5,x1 in ID
    task automatic set_load_use();
        mem_read_e = 1'b1; rd_wen_e = 1'b1; rd_addr_e = 5'd5;
        rs1_addr_d = 5'd5; rs1_en_d = 1'b1;
        rs2_addr_d = 5'd1; rs2_en_d = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        set_load_use();
        dmem_req_m = 1'b1;
        mdu_start_e = 1'b1;
        tick();
        total++;
        if (ctrl !== C_NONE) begin
            bad++; $display("[TB] FAIL reset_ctrl got=%b exp=%b", ctrl, C_NONE);
        end
        total++;
        if (stall_cnt !== 8'd0 || flush_cnt !== 8'd0) begin
            bad++; $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
        rst = 1'b0;
        clear_inputs();
        #1;
        total++;
        if (ctrl !== C_NONE) begin
            bad++; $display("[TB] FAIL reset_idle got=%b exp=%b", ctrl, C_NONE);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        #1;
        total++;
        if (ctrl !== C_LU) begin
            bad++; $display("[TB] FAIL lu_rs1 got=%b exp=%b", ctrl, C_LU);
        end
        tick();
        clear_inputs();
        #1;
        total++;
        if (ctrl !== C_NONE) begin
            bad++; $display("[TB] FAIL lu_after got=%b exp=%b", ctrl, C_NONE);
        end
        total++;
        if (stall_cnt !== 8'd1) begin
            bad++; $display("[TB] FAIL lu_stall_cnt got=%0d exp=1", stall_cnt);
        end
        // Hazard through rs2 only
        set_load_use();
        rs1_addr_d = 5'd7; rs2_addr_d = 5'd5;
        #1;
        total++;
        if (ctrl !== C_LU) begin
            bad++; $display("[TB] FAIL lu_rs2 got=%b exp=%b", ctrl, C_LU);
        end
        tick();
        clear_inputs();
        #1;
    endtask

    task automatic test_no_hazard();
        do_reset();
        set_load_use();
        rd_addr_e = 5'd0; rs1_addr_d = 5'd0;
        #1;
        total++;
        if (ctrl !== C_NONE) begin
            bad++; $display("[TB] FAIL lu_x0 got=%b exp=%b", ctrl, C_NONE);
        end
        tick();
        set_load_use();
        rs1_en_d = 1'b0;
        #1;
        total++;
        if (ctrl !== C_NONE) begin
            bad++; $display("[TB] FAIL lu_rs1_dis got=%b exp=%b", ctrl, C_NONE);
        end
        tick();
        set_load_use();
        mem_read_e = 1'b0;
        #1;
        total++;
        if (ctrl !== C_NONE) begin
            bad++; $display("[TB] FAIL lu_not_load got=%b exp=%b", ctrl, C_NONE);
        end
        tick();
        clear_inputs();
        #1;
        total++;
        if (stall_cnt !== 8'd0) begin
            bad++; $display("[TB] FAIL nohz_stall_cnt got=%0d exp=0", stall_cnt);
        end
    endtask

    task automatic test_branch_lu();
        do_reset();
        set_load_use();
        branch_taken_e = 1'b1;
        #1;
        total++;
        if (ctrl !== C_BR) begin
            bad++; $display("[TB] FAIL br_lu got=%b exp=%b", ctrl, C_BR);
        end
        tick();
        clear_inputs();
        #1;
        total++;
        if (flush_cnt !== 8'd1 || stall_cnt !== 8'd0) begin
            bad++; $display("[TB] FAIL br_cnt got=%0d/%0d exp=1/0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        dmem_req_m = 1'b1; dmem_ready = 1'b0; branch_taken_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctrl !== C_MEM) begin
                bad++; $display("[TB] FAIL mem_wait[%0d] got=%b exp=%b", i, ctrl, C_MEM);
            end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        total++;
        if (ctrl !== C_BR) begin
            bad++; $display("[TB] FAIL mem_release got=%b exp=%b", ctrl, C_BR);
        end
        tick();
        clear_inputs();
        #1;
        total++;
        if (stall_cnt !== 8'd3 || flush_cnt !== 8'd1) begin
            bad++; $display("[TB] FAIL mem_cnt got=%0d/%0d exp=3/1", stall_cnt, flush_cnt);
        end
        total++;
        if (ctrl !== C_NONE) begin
            bad++; $display("[TB] FAIL mem_run got=%b exp=%b", ctrl, C_NONE);
        end
    endtask

    task automatic test_mdu();
        do_reset();
        mdu_start_e = 1'b1; mdu_done = 1'b1;
        #1;
        total++;
        if (ctrl !== C_NONE) begin
            bad++; $display("[TB] FAIL mdu_fast got=%b exp=%b", ctrl, C_NONE);
        end
        tick();
        mdu_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (ctrl !== C_MDU) begin
                bad++; $display("[TB] FAIL mdu_wait[%0d] got=%b exp=%b", i, ctrl, C_MDU);
            end
            tick();
        end
        mdu_done = 1'b1;
        #1;
        total++;
        if (ctrl !== C_NONE) begin
            bad++; $display("[TB] FAIL mdu_done got=%b exp=%b", ctrl, C_NONE);
        end
        tick();
        // Back in RUN: a load-use must now be reported instead of an MDU stall
        clear_inputs();
        set_load_use();
        #1;
        total++;
        if (ctrl !== C_LU) begin
            bad++; $display("[TB] FAIL mdu_run got=%b exp=%b", ctrl, C_LU);
        end
        tick();
        clear_inputs();
        #1;
        total++;
        if (stall_cnt !== 8'd6) begin
            bad++; $display("[TB] FAIL mdu_stall_cnt got=%0d exp=6", stall_cnt);
        end
    endtask

    task automatic test_mdu_timeout();
        do_reset();
        mdu_start_e = 1'b1; mdu_done = 1'b0;
        repeat (7) tick();
        total++;
        if (ctrl !== C_MDU) begin
            bad++; $display("[TB] FAIL to_before got=%b exp=%b", ctrl, C_MDU);
        end
        tick();
        total++;
        if (ctrl !== C_MDU_TO) begin
            bad++; $display("[TB] FAIL to_set got=%b exp=%b", ctrl, C_MDU_TO);
        end
        repeat (3) tick();
        total++;
        if (ctrl !== C_MDU_TO) begin
            bad++; $display("[TB] FAIL to_sticky got=%b exp=%b", ctrl, C_MDU_TO);
        end
        rst = 1'b1;
        #1;
        total++;
        if (ctrl !== C_NONE || stall_cnt !== 8'd0) begin
            bad++; $display("[TB] FAIL to_rst got=%b/%0d exp=%b/0", ctrl, stall_cnt, C_NONE);
        end
        tick();
        rst = 1'b0;
        clear_inputs();
        set_load_use();
        #1;
        total++;
        if (ctrl !== C_LU) begin
            bad++; $display("[TB] FAIL to_run got=%b exp=%b", ctrl, C_LU);
        end
        tick();
        clear_inputs();
        #1;
    endtask

    task automatic test_rst_mem_wait();
        do_reset();
        dmem_req_m = 1'b1; dmem_ready = 1'b0; branch_taken_e = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        dmem_ready = 1'b1;
        #1;
        total++;
        if (ctrl !== C_NONE) begin
            bad++; $display("[TB] FAIL rst_mem_noreplay got=%b exp=%b", ctrl, C_NONE);
        end
        tick();
        total++;
        if (flush_cnt !== 8'd0) begin
            bad++; $display("[TB] FAIL rst_mem_flush_cnt got=%0d exp=0", flush_cnt);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        dmem_req_m = 1'b1; dmem_ready = 1'b0;
        repeat (300) tick();
        total++;
        if (stall_cnt !== 8'hFF) begin
            bad++; $display("[TB] FAIL sat_stall_cnt got=%0d exp=255", stall_cnt);
        end
        total++;
        if (ctrl !== C_MEM) begin
            bad++; $display("[TB] FAIL sat_ctrl got=%b exp=%b", ctrl, C_MEM);
        end
        dmem_ready = 1'b1;
        tick();
        clear_inputs();
        #1;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_lu();
        test_mem_wait();
        test_mdu();
        test_mdu_timeout();
        test_rst_mem_wait();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule
